// File: rtl/key_sched_ctrl_pkg.sv
// rtl/key_sched_ctrl_pkg.sv - shared AES-128 key schedule constants, state encoding and S-box
package key_sched_ctrl_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/key_sched_ctrl_gfunction.sv
// rtl/key_sched_ctrl_gfunction.sv - AES key-expansion g function: RotWord, SubWord, Rcon
import key_sched_ctrl_pkg::*;

module key_sched_ctrl_gfunction (
  input  logic [AES_WORD_W-1:0] val,
  input  logic [31:0]           round,
  output logic [AES_WORD_W-1:0] gval
);

  logic [31:0] rot;
  logic [31:0] sub;
  logic [7:0]  rcon;

  // Rotate left by one byte, substitute each byte, then fold the round constant into the top byte.
  always_comb begin
    rot  = {val[23:0], val[31:24]};
    sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    rcon = 8'h00;
    case (round)
      32'd1:   rcon = 8'h01;
      32'd2:   rcon = 8'h02;
      32'd3:   rcon = 8'h04;
      32'd4:   rcon = 8'h08;
      32'd5:   rcon = 8'h10;
      32'd6:   rcon = 8'h20;
      32'd7:   rcon = 8'h40;
      32'd8:   rcon = 8'h80;
      32'd9:   rcon = 8'h1b;
      32'd10:  rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    gval = sub ^ {rcon, 24'h000000};
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - iterative AES-128 key expansion with round-key store and stream
import key_sched_ctrl_pkg::*;

module key_sched_ctrl #(
  parameter int NR    = AES_NR,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_valid,
  output logic                 rk_valid,
  output logic [IDX_W-1:0]     rk_idx,
  output logic [AES_KEY_W-1:0] rk_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [AES_KEY_W-1:0] rd_key
);

  localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NR);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rnd_q;
  logic [AES_KEY_W-1:0]   work_q;
  logic [AES_KEY_W-1:0]   slots [0:NR];
  logic                   accept, step, last;
  logic [AES_WORD_W-1:0]  g, n0, n1, n2, n3;
  logic [AES_KEY_W-1:0]   next_key;

  key_sched_ctrl_gfunction u_gfunc (
    .val   (work_q[31:0]),
    .round ({{(32-IDX_W){1'b0}}, rnd_q}),
    .gval  (g)
  );

  // Word chain: each new word is the previous round's word xor the word just produced.
  always_comb begin
    n0       = work_q[127:96] ^ g;
    n1       = work_q[95:64]  ^ n0;
    n2       = work_q[63:32]  ^ n1;
    n3       = work_q[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        step = 1'b1;
        if (rnd_q == LAST_RND) begin
          last    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round counter, working key, register file and stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q      <= '0;
      work_q     <= '0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      rk_valid   <= 1'b0;
      rk_idx     <= '0;
      rk_data    <= '0;
      for (int i = 0; i <= NR; i++) slots[i] <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (accept) begin
        slots[0]   <= key_in;
        work_q     <= key_in;
        rnd_q      <= IDX_W'(1);
        keys_valid <= 1'b0;
        rk_valid   <= 1'b1;
        rk_idx     <= '0;
        rk_data    <= key_in;
      end else if (step) begin
        slots[rnd_q] <= next_key;
        work_q       <= next_key;
        rk_valid     <= 1'b1;
        rk_idx       <= rnd_q;
        rk_data      <= next_key;
        rnd_q        <= rnd_q + IDX_W'(1);
        if (last) begin
          done       <= 1'b1;
          keys_valid <= 1'b1;
        end
      end
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = ~ready;
  assign rd_key = (rd_idx <= LAST_RND) ? slots[rd_idx] : '0;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - directed self-checking bench for key_sched_ctrl
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         ready, busy, done, keys_valid, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int checks   = 0;
  int failures = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] fips_key;
  logic [127:0] zero_rk1, zero_rk10;

  always #5 clk = ~clk;

  key_sched_ctrl #(.NR(10), .IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  task automatic do_accept(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, done, keys_valid, rk_valid} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000", {ready, busy, done, keys_valid, rk_valid});
    end
    checks++;
    if (rk_idx !== 4'd0 || rk_data !== 128'd0 || rd_key !== 128'd0) begin
      failures++;
      $display("FAIL reset_data idx=%0d data=%h rd=%h exp 0", rk_idx, rk_data, rd_key);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips;
    @(negedge clk);
    do_accept(fips_key);
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_data !== fips_rk[0] || busy !== 1'b1 || keys_valid !== 1'b0) begin
      failures++;
      $display("FAIL fips_accept v=%b idx=%0d data=%h busy=%b kv=%b", rk_valid, rk_idx, rk_data, busy, keys_valid);
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(k) || rk_data !== fips_rk[k] ||
          done !== (k == 10) || keys_valid !== (k == 10)) begin
        failures++;
        $display("FAIL fips_round%0d v=%b idx=%0d data=%h done=%b kv=%b exp data=%h",
                 k, rk_valid, rk_idx, rk_data, done, keys_valid, fips_rk[k]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (rk_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1 || keys_valid !== 1'b1) begin
      failures++;
      $display("FAIL fips_after v=%b done=%b ready=%b kv=%b exp 0 0 1 1", rk_valid, done, ready, keys_valid);
    end
  endtask

  task automatic test_readback;
    logic [127:0] exp_key;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      exp_key = (i <= 10) ? fips_rk[i] : 128'd0;
      checks++;
      if (rd_key !== exp_key) begin
        failures++;
        $display("FAIL readback_idx%0d got=%h exp=%h", i, rd_key, exp_key);
      end
    end
    rd_idx = '0;
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    @(negedge clk);
    do_accept(128'd0);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (k <= 10) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'(k)) begin
          failures++;
          $display("FAIL ignore_seq%0d v=%b idx=%0d", k, rk_valid, rk_idx);
        end
      end
      if (k == 1) begin
        checks++;
        if (rk_data !== zero_rk1) begin
          failures++;
          $display("FAIL zero_rk1 got=%h exp=%h", rk_data, zero_rk1);
        end
      end
      if (k == 10) begin
        checks++;
        if (rk_data !== zero_rk10 || done !== 1'b1) begin
          failures++;
          $display("FAIL zero_rk10 got=%h done=%b exp=%h", rk_data, done, zero_rk10);
        end
      end
      if (k == 2 || k == 6) begin
        start = 1'b1; key_in = fips_key;
      end else begin
        start = 1'b0; key_in = '0;
      end
    end
    checks++;
    if (ndone != 1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d ready=%b exp 1 1", ndone, ready);
    end
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    @(negedge clk);
    do_accept(fips_key);
    while (rk_idx !== 4'd5 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (rk_idx !== 4'd5) begin
      failures++;
      $display("FAIL midrst_reach idx=%0d exp 5", rk_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, busy, done, keys_valid, rk_valid} !== 5'b10000 || rk_idx !== 4'd0 ||
        rk_data !== 128'd0 || rd_key !== 128'd0) begin
      failures++;
      $display("FAIL midrst_state flags=%b idx=%0d data=%h rd=%h", {ready, busy, done, keys_valid, rk_valid}, rk_idx, rk_data, rd_key);
    end
    @(negedge clk);
    rst = 1'b0;
    test_fips();
    test_readback();
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start  = 1'b1;
    key_in = fips_key;
    for (int k = 0; k <= 22; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(k % 11) || rk_data !== fips_rk[k % 11] ||
          done !== (k % 11 == 10) || keys_valid !== (k % 11 == 10)) begin
        failures++;
        $display("FAIL b2b_cycle%0d v=%b idx=%0d done=%b kv=%b data=%h", k, rk_valid, rk_idx, done, keys_valid, rk_data);
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || keys_valid !== 1'b1 || rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain ready=%b kv=%b v=%b exp 1 1 0", ready, keys_valid, rk_valid);
    end
  endtask

  initial begin
    fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk1  = 128'h62636363626363636263636362636363;
    zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    test_reset();
    test_fips();
    test_readback();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
